// File: rtl/frame_strobe_writer.sv
// Frame strobe writer: decodes header/data word pairs from the bitstream loader and
// drives one tile column's frame latch array. Each frame write presents data, waits one
// setup cycle, pulses exactly one FrameStrobe bit for StrobeCycles cycles, then holds
// the data for one more cycle before the next word is accepted.
// Optional build macro FRAME_PARITY_EN: header bit 15 carries the even parity of the
// following data word; a mismatching data word is discarded and flagged as an error.
module frame_strobe_writer #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned StrobeCycles    = 2,
    parameter logic [15:0] HeaderTag       = 16'hFAB0
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] WordData,
    input  logic                       WordValid,
    output logic                       WordReady,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       Busy,
    output logic                       Error,
    input  logic                       ErrorClear
);

    localparam int unsigned CntW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(StrobeCycles - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitData,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    state_e                     state_q, state_d;
    logic [4:0]                 idx_q, idx_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [FrameBitsPerRow-1:0] data_q, data_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic                       busy_q, busy_d;
    logic                       error_q, error_d;
    logic                       err_set;
    logic                       accept;
`ifdef FRAME_PARITY_EN
    logic                       par_q, par_d;
`endif

    // WordReady is the only unregistered output: decoded straight from the state.
    assign WordReady = (state_q == StIdle) || (state_q == StWaitData);
    assign accept    = WordValid && WordReady;

    // Next-state decode, frame data capture and error detection.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_set = 1'b0;
`ifdef FRAME_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WordData[31:16] == HeaderTag) begin
                        if (32'(WordData[4:0]) >= MaxFramesPerCol) begin
                            err_set = 1'b1;
                        end else begin
                            idx_d   = WordData[4:0];
`ifdef FRAME_PARITY_EN
                            par_d   = WordData[15];
`endif
                            state_d = StWaitData;
                        end
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            StWaitData: begin
                // The data word is never checked for the header tag.
                if (accept) begin
`ifdef FRAME_PARITY_EN
                    if ((^WordData) != par_q) begin
                        err_set = 1'b1;
                        state_d = StIdle;
                    end else begin
                        data_d  = WordData;
                        state_d = StSetup;
                    end
`else
                    data_d  = WordData;
                    state_d = StSetup;
`endif
                end
            end
            StSetup: begin
                cnt_d   = CntLoad;
                state_d = StStrobe;
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered outputs follow the next state so they line up with it cycle for cycle.
    always_comb begin
        strobe_d = '0;
        if (state_d == StStrobe) begin
            for (int unsigned i = 0; i < MaxFramesPerCol; i++) begin
                strobe_d[i] = (idx_q == 5'(i));
            end
        end
        busy_d  = (state_d != StIdle);
        // A new error wins over a simultaneous clear.
        error_d = err_set | (error_q & ~ErrorClear);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef FRAME_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
`ifdef FRAME_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign FrameData   = data_q;
    assign FrameStrobe = strobe_q;
    assign Busy        = busy_q;
    assign Error       = error_q;

endmodule

// File: doc/frame_strobe_writer.md
Name: frame_strobe_writer

Overview:
Configuration-side writer that drives the frame latch array of one tile column. It accepts a stream of 32-bit configuration words over a valid/ready handshake and decodes header/data word pairs. For each pair it presents the data on FrameData and pulses exactly one FrameStrobe line, with setup and hold margins. It sits between the bitstream loader and the per-tile config memories, whose latches are transparent while their FrameStrobe bit is high.

Parameters:
MaxFramesPerCol, 20, number of FrameStrobe lines (frames per column); legal range 1..32
FrameBitsPerRow, 32, FrameData width and input word width; fixed at 32
StrobeCycles, 2, cycles FrameStrobe stays high per frame write; legal range >=1
HeaderTag, 16'hFAB0, value of word[31:16] that marks a header word

Ports:
CLK  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
WordData  input  FrameBitsPerRow  incoming configuration word
WordValid  input  1  WordData valid
WordReady  output  1  block can accept a word this cycle
FrameData  output  FrameBitsPerRow  registered frame data to latch array
FrameStrobe  output  MaxFramesPerCol  registered one-hot frame latch enable
Busy  output  1  high in every state except IDLE
Error  output  1  sticky protocol error flag
ErrorClear  input  1  synchronous clear of Error

Behaviour:
- Reset: asynchronous and active-low. Forces state IDLE, FrameData=0, FrameStrobe=0, Error=0, Busy=0 and WordReady=1 immediately, with no clock required. A reset during STROBE drops FrameStrobe at once.
- All outputs are registered except WordReady. WordReady is decoded from the state: 1 in IDLE and WAIT_DATA, 0 elsewhere.
- A word transfers on a rising edge where WordValid and WordReady are both high.
- States are IDLE, WAIT_DATA, SETUP, STROBE and HOLD.
- IDLE, word accepted with WordData[31:16]==HeaderTag:
  - Latch frame index = WordData[4:0], then go to WAIT_DATA.
  - If the index >= MaxFramesPerCol, set Error and stay in IDLE. The frame is discarded.
- IDLE, word accepted without the tag: discard it, set Error, stay in IDLE.
- WAIT_DATA, word accepted: the word is data, and is never checked for the tag. Load FrameData with it and go to SETUP.
- SETUP: lasts 1 cycle. FrameData is stable and FrameStrobe is 0. Next state is STROBE.
- STROBE:
  - FrameStrobe[index]=1, all other bits 0.
  - A down-counter loaded with StrobeCycles-1 gives exactly StrobeCycles cycles, then the state moves to HOLD.
- HOLD: lasts 1 cycle. FrameStrobe is 0 and FrameData is unchanged. Next state is IDLE.
- Timing from the data-accept edge:
  - FrameData updates at that edge.
  - FrameStrobe rises 1 edge later and stays high StrobeCycles cycles.
  - WordReady returns StrobeCycles+2 edges after the accept edge.
- FrameData holds its last value in IDLE; it is not cleared after a write.
- FrameStrobe is never multi-hot and never changes in the same cycle as FrameData.
- WordValid while WordReady=0 has no effect, and the word is not consumed. The source must hold the word.
- Error and ErrorClear:
  - Error stays set until ErrorClear is high at a rising edge.
  - If a new error and ErrorClear occur in the same cycle, the error wins and Error stays 1.
  - ErrorClear never affects the state.

Optional Feature:
FRAME_PARITY_EN
- Defined: header bit[15] carries even parity of the following data word.
  - At data accept, if XOR(WordData)!=header[15], set Error, do not update FrameData, return to IDLE, and assert no strobe.
  - WordReady is 1 in the cycle after such a discard.
- Not defined: header bit[15] is ignored and there is no parity logic.

Test Plan:
- Basic write: header 32'hFAB0_0003 then data 32'hDEAD_BEEF with StrobeCycles=2 -> FrameData=32'hDEAD_BEEF at the accept edge; FrameStrobe=20'h00008 for exactly 2 cycles starting 1 cycle later; Busy high throughout; WordReady=1 again 4 edges after data accept.
- Back-to-back frames: headers for index 0 and 19 with WordValid held high continuously -> two separate single-bit strobes (bit 0, then bit 19); no overlap; FrameData never changes while a strobe is high; no word lost.
- Bad input: header 32'hFAB0_0014 (index 20), then word 32'h1234_5678 in IDLE -> Error=1, no strobe asserted, still IDLE; ErrorClear pulse -> Error=0; simultaneous new bad header and ErrorClear -> Error stays 1.
- Reset mid-strobe: drop resetn during STROBE, asynchronously to CLK -> FrameStrobe=0 and FrameData=0 immediately; after release, WordReady=1 and a fresh header/data pair completes normally.
- Stall: WordValid high during SETUP/STROBE/HOLD -> word held by the source, not consumed; accepted on the first IDLE cycle.
- With FRAME_PARITY_EN: header 32'hFAB0_8001 with data 32'h0000_0001 (odd parity, matches) -> strobe bit 1; header 32'hFAB0_0001 with the same data -> Error=1, no strobe, FrameData unchanged.
